// File: rtl/wb_unchunk.sv
// Assembles CHUNK-bit Wishbone writes (least-significant chunk first) into one WIDTH-bit word
// and offers it to a sink with a store/ready handshake. Define WB_UNCHUNK_FLUSH_EN for flush_i.
module wb_unchunk #(
  parameter int WIDTH = 48,
  parameter int CHUNK = 8,
  parameter int COUNT = (WIDTH + CHUNK - 1) / CHUNK - 1,
  parameter int CBITS = 3,
  parameter int DELAY = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic             we_i,
  output logic             ack_o,
  input  logic [CHUNK-1:0] dat_i,
  output logic [CHUNK-1:0] dat_o,
  output logic             store_o,
  input  logic             ready_i,
`ifdef WB_UNCHUNK_FLUSH_EN
  input  logic             flush_i,
`endif
  output logic [WIDTH-1:0] value_o
);

  localparam int BUFW = (COUNT + 1) * CHUNK;
  localparam logic [CBITS-1:0] LAST = CBITS'(COUNT);

  // Handshakes: a Wishbone access completes on the single-cycle ack_o pulse; an assembled
  // word transfers on any edge where store_o and ready_i are both high, and value_o holds
  // steady until then.
  logic [BUFW-1:0]  buf_q;
  logic [CBITS-1:0] count_q;
  logic             full_q;
  logic             flushing;
  logic             accept;
  logic             rd_req;
  logic             wrap;
  logic [CHUNK-1:0] status;
  logic             unused_delay;

  // Register-assignment delay only matters to legacy simulation models.
  assign unused_delay = (DELAY != 0);

  assign accept = cyc_i & stb_i & we_i & ~ack_o & ~full_q & ~flushing;
  assign rd_req = cyc_i & stb_i & ~we_i & ~ack_o;
  assign wrap   = (count_q == LAST);

  always_comb begin
    status              = '0;
    status[CHUNK-1]     = full_q;
    status[CBITS-1:0]   = count_q;
  end

`ifdef WB_UNCHUNK_FLUSH_EN
  logic flushing_q;
  logic flush_start;

  // A write landing in the same cycle wins; the flush request is then ignored.
  assign flush_start = flush_i & (count_q != '0) & ~full_q & ~flushing_q & ~accept;
  assign flushing    = flushing_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flushing_q <= 1'b0;
    end else if (flush_start) begin
      flushing_q <= 1'b1;
    end else if (flushing_q && wrap) begin
      flushing_q <= 1'b0;
    end
  end
`else
  assign flushing = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_o   <= 1'b0;
      full_q  <= 1'b0;
      count_q <= '0;
      dat_o   <= '0;
      buf_q   <= '0;
    end else begin
      ack_o <= accept | rd_req;
      if (rd_req) begin
        dat_o <= status;
      end
      // New chunks enter at the top so the first one ends up in the low bits.
      if (accept || flushing) begin
        buf_q   <= {(accept ? dat_i : {CHUNK{1'b0}}), buf_q[BUFW-1:CHUNK]};
        count_q <= wrap ? '0 : count_q + CBITS'(1);
        if (wrap) begin
          full_q <= 1'b1;
        end
      end else if (full_q && ready_i) begin
        full_q <= 1'b0;
      end
    end
  end

  assign store_o = full_q;
  assign value_o = buf_q[WIDTH-1:0];

endmodule

// File: tb/tb_wb_unchunk.sv
// Directed bench for wb_unchunk: a chunk-queue model predicts assembled words, a negedge
// compare process checks store_o/value_o every cycle, and literals pin the model.
module tb_wb_unchunk;

  localparam int WIDTH = 48;
  localparam int CHUNK = 8;
  localparam int COUNT = (WIDTH + CHUNK - 1) / CHUNK - 1;
  localparam int BUFW  = (COUNT + 1) * CHUNK;

  logic             clk_i;
  logic             rst_ni;
  logic             cyc_i, stb_i, we_i, ack_o;
  logic [CHUNK-1:0] dat_i, dat_o;
  logic             store_o, ready_i, flush_i;
  logic [WIDTH-1:0] value_o;

  logic             cyc12, stb12, we12, ack12, store12, ready12;
  logic [7:0]       dat12_i, dat12_o;
  logic [11:0]      value12;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [CHUNK-1:0] chunks[$];

  wb_unchunk #(.WIDTH(WIDTH), .CHUNK(CHUNK), .CBITS(3)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .ack_o(ack_o), .dat_i(dat_i), .dat_o(dat_o), .store_o(store_o), .ready_i(ready_i),
`ifdef WB_UNCHUNK_FLUSH_EN
    .flush_i(flush_i),
`endif
    .value_o(value_o)
  );

  wb_unchunk #(.WIDTH(12), .CHUNK(8), .CBITS(3)) u_dut12 (
    .clk_i(clk_i), .rst_ni(rst_ni), .cyc_i(cyc12), .stb_i(stb12), .we_i(we12),
    .ack_o(ack12), .dat_i(dat12_i), .dat_o(dat12_o), .store_o(store12), .ready_i(ready12),
`ifdef WB_UNCHUNK_FLUSH_EN
    .flush_i(1'b0),
`endif
    .value_o(value12)
  );

  // clock/reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: a word is simply the accepted chunks concatenated, first chunk lowest
  task automatic model_complete();
    logic [BUFW-1:0] w;
    w = '0;
    for (int i = 0; i < chunks.size(); i++) w = w | (BUFW'(chunks[i]) << (i * CHUNK));
    exp_q.push_back(w[WIDTH-1:0]);
    chunks.delete();
  endtask

  task automatic model_write(input logic [CHUNK-1:0] d);
    chunks.push_back(d);
    if (chunks.size() == COUNT + 1) model_complete();
  endtask

  task automatic model_flush();
    while (chunks.size() < COUNT + 1) chunks.push_back('0);
    model_complete();
  endtask

  function automatic logic [CHUNK-1:0] model_status();
    logic [CHUNK-1:0] s;
    s = '0;
    s[CHUNK-1] = (exp_q.size() != 0);
    s[2:0] = 3'(chunks.size());
    return s;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    chunks.delete();
  endtask

  // scoreboard compare
  always @(negedge clk_i) begin
    if (rst_ni) begin
      check("store_vs_model", 64'(store_o), 64'(exp_q.size() != 0));
      if (store_o && exp_q.size() != 0) begin
        check("value_vs_model", 64'(value_o), 64'(exp_q[0]));
        if (ready_i) void'(exp_q.pop_front());
      end
    end
  end

  // drivers
  task automatic idle();
    @(posedge clk_i); #1;
  endtask

  task automatic wb_write(input logic [CHUNK-1:0] d);
    int n;
    n = 0;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; dat_i = d;
    do begin
      @(posedge clk_i); #1;
      n++;
    end while (!ack_o && n < 20);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    check("wr_ack", 64'(ack_o), 64'd1);
    check("wr_latency", 64'(n), 64'd1);
    if (ack_o) model_write(d);
  endtask

  task automatic wr(input logic [CHUNK-1:0] d);
    wb_write(d);
    idle();
  endtask

  task automatic rd_status(input logic [CHUNK-1:0] exp_lit);
    int n;
    logic [CHUNK-1:0] exp_m;
    n = 0;
    exp_m = model_status();
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0;
    do begin
      @(posedge clk_i); #1;
      n++;
    end while (!ack_o && n < 20);
    cyc_i = 1'b0; stb_i = 1'b0;
    check("rd_ack", 64'(ack_o), 64'd1);
    check("rd_status_model", 64'(dat_o), 64'(exp_m));
    check("rd_status_literal", 64'(dat_o), 64'(exp_lit));
    idle();
  endtask

  task automatic ready_pulse();
    ready_i = 1'b1;
    idle();
    ready_i = 1'b0;
    check("store_after_ready", 64'(store_o), 64'd0);
  endtask

  task automatic wr12(input logic [7:0] d);
    int n;
    n = 0;
    cyc12 = 1'b1; stb12 = 1'b1; we12 = 1'b1; dat12_i = d;
    do begin
      @(posedge clk_i); #1;
      n++;
    end while (!ack12 && n < 20);
    cyc12 = 1'b0; stb12 = 1'b0; we12 = 1'b0;
    check("w12_ack", 64'(ack12), 64'd1);
    idle();
  endtask

  initial begin
    rst_ni = 1'b0;
    cyc_i = 0; stb_i = 0; we_i = 0; dat_i = '0; ready_i = 0; flush_i = 0;
    cyc12 = 0; stb12 = 0; we12 = 0; dat12_i = '0; ready12 = 0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_ack", 64'(ack_o), 64'd0);
    check("reset_store", 64'(store_o), 64'd0);
    rst_ni = 1'b1;
    idle();

    // basic word, held until ready
    for (int i = 1; i <= 6; i++) wr(8'(i * 8'h11));
    check("word1_literal", 64'(value_o), 64'h665544332211);
    check("word1_store", 64'(store_o), 64'd1);
    idle(); idle();
    ready_pulse();

    // write stalled by a pending word, then accepted after the handshake
    for (int i = 0; i < 6; i++) wr(8'hA0 + 8'(i));
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; dat_i = 8'hAA;
    repeat (3) begin
      idle();
      check("stall_no_ack", 64'(ack_o), 64'd0);
    end
    ready_i = 1'b1;
    idle();
    ready_i = 1'b0;
    check("stall_store_fell", 64'(store_o), 64'd0);
    check("stall_not_yet", 64'(ack_o), 64'd0);
    idle();
    check("stall_ack_after_ready", 64'(ack_o), 64'd1);
    if (ack_o) model_write(8'hAA);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    idle();

    // status reads: partial count, then full
    wr(8'hBB); wr(8'hCC);
    rd_status(8'h03);
    wr(8'hDD); wr(8'hEE); wr(8'hFF);
    check("word3_literal", 64'(value_o), 64'hFFEEDDCCBBAA);
    rd_status(8'h80);
    ready_pulse();

    // reset while a word is pending and ack is high
    for (int i = 0; i < 5; i++) wr(8'h5A);
    wb_write(8'h5B);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_async_ack", 64'(ack_o), 64'd0);
    check("rst_async_store", 64'(store_o), 64'd0);
    model_reset();
    @(posedge clk_i); #1 rst_ni = 1'b1;
    idle();
    rd_status(8'h00);

    // reset mid-word discards the partial word
    wr(8'h10);
    wb_write(8'h20);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_mid_ack", 64'(ack_o), 64'd0);
    model_reset();
    @(posedge clk_i); #1 rst_ni = 1'b1;
    idle();
    for (int i = 1; i <= 6; i++) wr(8'(i));
    check("word_after_rst_literal", 64'(value_o), 64'h060504030201);
    ready_pulse();

    // WIDTH not a multiple of CHUNK
    wr12(8'hBC);
    wr12(8'hFA);
    check("w12_store", 64'(store12), 64'd1);
    check("w12_value", 64'(value12), 64'hABC);
    ready12 = 1'b1;
    idle();
    ready12 = 1'b0;
    check("w12_store_fell", 64'(store12), 64'd0);

`ifdef WB_UNCHUNK_FLUSH_EN
    // flush with no partial word is ignored
    flush_i = 1'b1;
    idle();
    flush_i = 1'b0;
    idle(); idle();
    rd_status(8'h00);

    // flush a two-chunk partial word; writes stall meanwhile
    wr(8'h12); wr(8'h34);
    flush_i = 1'b1;
    idle();
    flush_i = 1'b0;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; dat_i = 8'h77;
    for (int k = 1; k <= 4; k++) begin
      idle();
      check("flush_no_ack", 64'(ack_o), 64'd0);
      if (k == 4) model_flush();
      check("flush_store", 64'(store_o), 64'(k == 4));
    end
    check("flush_literal", 64'(value_o), 64'h000000003412);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    idle();
    ready_pulse();
`endif

    idle(); idle();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
